// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types and constants for the edge window controller
package edge_pkg;

    // 3x3 neighbourhood used by the edge calculator
    localparam int WIN_SIZE = 3;
    localparam int WIN_PIX  = WIN_SIZE * WIN_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_WIN   = 3'd3,
        ST_DONE  = 3'd4
    } edge_state_t;

    // Row offset inside the window of the k-th fetched pixel (row-major order)
    function automatic logic [1:0] k_row(input logic [3:0] k);
        return 2'(k / 4'(WIN_SIZE));
    endfunction

    // Column offset inside the window of the k-th fetched pixel
    function automatic logic [1:0] k_col(input logic [3:0] k);
        return 2'(k % 4'(WIN_SIZE));
    endfunction

endpackage

// File: rtl/edge_window_ctrl.sv
// rtl/edge_window_ctrl.sv - walks a 3x3 window over the image and fetches its pixels
import edge_pkg::*;

module edge_window_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              pix_req,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic              pix_valid,
    output logic              shift_enable,
    output logic              clear,
    output logic              window_valid,
    input  logic              win_ack,
    output logic [15:0]       win_x,
    output logic [15:0]       win_y,
    output logic              busy,
    output logic              done
);

    // Last legal top-left coordinates: the window must fit inside the image
    localparam logic [15:0] LAST_X = 16'(IMG_W - WIN_SIZE);
    localparam logic [15:0] LAST_Y = 16'(IMG_H - WIN_SIZE);
    localparam logic [3:0]  LAST_K = 4'(WIN_PIX - 1);

    edge_state_t state, state_nxt;
    logic [3:0]  k, k_nxt;
    logic [15:0] win_x_nxt, win_y_nxt;

    // State, fetch counter and window position registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            k     <= 4'd0;
            win_x <= 16'd0;
            win_y <= 16'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            win_x <= win_x_nxt;
            win_y <= win_y_nxt;
        end
    end

    // Next-state decode and Moore/Mealy outputs; pix_addr is only driven while fetching
    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        win_x_nxt    = win_x;
        win_y_nxt    = win_y;
        pix_req      = 1'b0;
        pix_addr     = '0;
        shift_enable = 1'b0;
        clear        = 1'b0;
        window_valid = 1'b0;
        busy         = (state != ST_IDLE);
        done         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                clear     = 1'b1;
                state_nxt = ST_FETCH;
                k_nxt     = 4'd0;
                win_x_nxt = 16'd0;
                win_y_nxt = 16'd0;
            end

            ST_FETCH: begin
                pix_req      = 1'b1;
                pix_addr     = ADDR_W'((32'(win_y) + 32'(k_row(k))) * 32'(IMG_W)
                                       + 32'(win_x) + 32'(k_col(k)));
                shift_enable = pix_valid;
                if (pix_valid) begin
                    if (k == LAST_K) begin
                        state_nxt = ST_WIN;
                        k_nxt     = 4'd0;
                    end else begin
                        k_nxt = k + 4'd1;
                    end
                end
            end

            ST_WIN: begin
                window_valid = 1'b1;
                if (win_ack) begin
                    if (win_x == LAST_X && win_y == LAST_Y) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FETCH;
                        if (win_x < LAST_X) begin
                            win_x_nxt = win_x + 16'd1;
                        end else begin
                            win_x_nxt = 16'd0;
                            win_y_nxt = win_y + 16'd1;
                        end
                    end
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_edge_window_ctrl.sv
// tb/tb_edge_window_ctrl.sv - randomized and directed checks of edge_window_ctrl
module tb_edge_window_ctrl;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int AW   = 19;
    localparam int NX   = W - 2;
    localparam int NWIN = (W - 2) * (H - 2);

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_FETCH = 2;
    localparam int M_WIN   = 3;
    localparam int M_DONE  = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_req;
    logic [AW-1:0] pix_addr;
    logic          pix_valid = 1'b0;
    logic          shift_enable;
    logic          clear;
    logic          window_valid;
    logic          win_ack = 1'b0;
    logic [15:0]   win_x;
    logic [15:0]   win_y;
    logic          busy;
    logic          done;

    edge_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .pix_req      (pix_req),
        .pix_addr     (pix_addr),
        .pix_valid    (pix_valid),
        .shift_enable (shift_enable),
        .clear        (clear),
        .window_valid (window_valid),
        .win_ack      (win_ack),
        .win_x        (win_x),
        .win_y        (win_y),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase, pixels accepted in the current window, window index
    int m_mode = M_IDLE;
    int m_n    = 0;
    int m_wi   = 0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_mode = M_IDLE;
            m_n    = 0;
            m_wi   = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_CLEAR;
                M_CLEAR: begin m_mode = M_FETCH; m_n = 0; m_wi = 0; end
                M_FETCH: if (pix_valid) begin
                    if (m_n == 8) begin m_mode = M_WIN; m_n = 0; end
                    else m_n++;
                end
                M_WIN: if (win_ack) begin
                    if (m_wi == NWIN - 1) m_mode = M_DONE;
                    else begin m_wi++; m_mode = M_FETCH; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    function automatic int exp_x();
        return m_wi % NX;
    endfunction
    function automatic int exp_y();
        return m_wi / NX;
    endfunction
    function automatic int exp_addr();
        return (exp_y() + m_n / 3) * W + exp_x() + m_n % 3;
    endfunction

    // Observation records
    int          cyc = 0;
    int          clr_cnt = 0, done_cnt = 0, shift_cnt = 0, wv_cycles = 0, wv_req = 0;
    logic        wv_prev = 1'b0;
    logic [31:0] q_addr[$];
    int          q_shift_cyc[$];
    int          q_wx[$], q_wy[$], q_wv_cyc[$];

    // Per-cycle compare against the model plus event recording
    always @(negedge clk) begin
        cyc++;
        check("busy",         busy,         m_mode != M_IDLE);
        check("clear",        clear,        m_mode == M_CLEAR);
        check("pix_req",      pix_req,      m_mode == M_FETCH);
        check("shift_enable", shift_enable, (m_mode == M_FETCH) && pix_valid);
        check("window_valid", window_valid, m_mode == M_WIN);
        check("done",         done,         m_mode == M_DONE);
        check("win_x",        win_x,        exp_x());
        check("win_y",        win_y,        exp_y());
        if (m_mode == M_FETCH) check("pix_addr", pix_addr, exp_addr());

        if (clear) begin clr_cnt++; shift_cnt = 0; end
        if (shift_enable) begin
            q_addr.push_back(32'(pix_addr));
            q_shift_cyc.push_back(cyc);
            shift_cnt++;
        end
        if (done) done_cnt++;
        if (window_valid) begin
            wv_cycles++;
            if (pix_req) wv_req++;
        end
        if (window_valid && !wv_prev) begin
            q_wx.push_back(int'(win_x));
            q_wy.push_back(int'(win_y));
            q_wv_cyc.push_back(cyc);
            check("shifts_per_window", shift_cnt, 9);
            shift_cnt = 0;
        end
        wv_prev = window_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; start = 1'b0; pix_valid = 1'b0; win_ack = 1'b0;
        #2;
        check("rst_busy",     busy,     0);
        check("rst_pix_req",  pix_req,  0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_win_x",    win_x,    0);
        check("rst_win_y",    win_y,    0);
        check("rst_done",     done,     0);
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic finish_frame();
        int budget;
        budget = 0;
        pix_valid = 1'b1; win_ack = 1'b1;
        while (m_mode != M_IDLE && budget < 2000) begin tick(); budget++; end
        pix_valid = 1'b0; win_ack = 1'b0;
        check("frame_finished", m_mode == M_IDLE, 1);
    endtask

    task automatic wait_win();
        int budget;
        budget = 0;
        while (m_mode != M_WIN && budget < 500) begin tick(); budget++; end
        check("reached_window", m_mode == M_WIN, 1);
    endtask

    task automatic run_frame(input int pv_pct, input int ack_pct, input bit junk_start);
        int budget, wbase, d0, idx;
        wbase = q_wx.size(); d0 = done_cnt; budget = 0;
        start = 1'b1; tick(); start = 1'b0;
        while (m_mode != M_IDLE && budget < 5000) begin
            pix_valid = ($urandom_range(99) < pv_pct);
            win_ack   = ($urandom_range(99) < ack_pct);
            start     = junk_start && (m_mode == M_FETCH || m_mode == M_WIN) && ($urandom_range(3) == 0);
            tick(); budget++;
        end
        start = 1'b0; pix_valid = 1'b0; win_ack = 1'b0;
        check("rand_frame_finished", m_mode == M_IDLE, 1);
        tick();
        check("rand_done_pulses", done_cnt - d0, 1);
        check("rand_window_count", q_wx.size() - wbase, NWIN);
        idx = wbase;
        for (int y = 0; y < H - 2; y++) begin
            for (int x = 0; x < W - 2; x++) begin
                check("rand_win_x", q_wx[idx], x);
                check("rand_win_y", q_wy[idx], y);
                idx++;
            end
        end
    endtask

    logic [31:0] exp_first[9];
    int          exp_wx[6];
    int          exp_wy[6];

    initial begin
        int base, wbase, c0, d0, v0, r0;
        exp_first = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        exp_wx    = '{0, 1, 2, 0, 1, 2};
        exp_wy    = '{0, 0, 0, 1, 1, 1};

        do_reset();

        // First window with data always ready
        base = q_addr.size(); wbase = q_wv_cyc.size(); c0 = clr_cnt;
        start = 1'b1; pix_valid = 1'b1; tick(); start = 1'b0;
        wait_win();
        tick();
        check("t1_shift_count", q_addr.size() - base, 9);
        for (int i = 0; i < 9; i++) check("t1_addr", q_addr[base + i], exp_first[i]);
        check("t1_clear_pulses", clr_cnt - c0, 1);
        check("t1_shift_span", q_shift_cyc[base + 8] - q_shift_cyc[base], 8);
        check("t1_wv_latency", q_wv_cyc[wbase] - q_shift_cyc[base + 8], 1);
        finish_frame();

        // Memory stall at k=4
        base = q_addr.size();
        start = 1'b1; pix_valid = 1'b1; tick(); start = 1'b0;
        begin
            int budget;
            budget = 0;
            while (!(m_mode == M_FETCH && m_n == 4) && budget < 100) begin tick(); budget++; end
        end
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b0;
            #3;
            check("t2_addr_held", pix_addr, 6);
            check("t2_no_shift", shift_enable, 0);
            tick();
        end
        pix_valid = 1'b1;
        wait_win();
        tick();
        check("t2_shift_count", q_addr.size() - base, 9);
        for (int i = 0; i < 9; i++) check("t2_addr", q_addr[base + i], exp_first[i]);
        finish_frame();

        // Full frame with immediate acknowledge
        wbase = q_wx.size(); d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        finish_frame();
        tick();
        check("t3_busy_low", busy, 0);
        check("t3_done_pulses", done_cnt - d0, 1);
        check("t3_window_count", q_wx.size() - wbase, 6);
        for (int i = 0; i < 6; i++) begin
            check("t3_win_x", q_wx[wbase + i], exp_wx[i]);
            check("t3_win_y", q_wy[wbase + i], exp_wy[i]);
        end

        // Acknowledge delayed: window held five cycles
        start = 1'b1; pix_valid = 1'b1; tick(); start = 1'b0;
        wait_win();
        v0 = wv_cycles; r0 = wv_req;
        repeat (4) tick();
        win_ack = 1'b1; tick(); win_ack = 1'b0;
        tick();
        check("t4_wv_cycles", wv_cycles - v0, 5);
        check("t4_req_while_waiting", wv_req - r0, 0);
        finish_frame();

        // Asynchronous reset at window (1,1), k=3
        d0 = done_cnt;
        start = 1'b1; pix_valid = 1'b1; win_ack = 1'b1; tick(); start = 1'b0;
        begin
            int budget;
            budget = 0;
            while (!(m_mode == M_FETCH && m_wi == 4 && m_n == 3) && budget < 500) begin tick(); budget++; end
            check("t5_reached_point", m_wi, 4);
        end
        #2 n_rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_pix_req", pix_req, 0);
        check("t5_pix_addr", pix_addr, 0);
        check("t5_shift", shift_enable, 0);
        check("t5_win_x", win_x, 0);
        check("t5_win_y", win_y, 0);
        check("t5_wv", window_valid, 0);
        pix_valid = 1'b0; win_ack = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (3) tick();
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_stays_idle", busy, 0);
        base = q_addr.size(); wbase = q_wx.size();
        start = 1'b1; pix_valid = 1'b1; tick(); start = 1'b0;
        wait_win();
        tick();
        check("t5_restart_x", q_wx[wbase], 0);
        check("t5_restart_y", q_wy[wbase], 0);
        check("t5_restart_addr", q_addr[base], 0);
        finish_frame();

        // Start pulsed while busy, then fully random frames
        run_frame(100, 100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_frame(20 + $urandom_range(80), 10 + $urandom_range(90), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/edge_window_ctrl.md
EDGE_WINDOW_CTRL -- requirements
Module: edge_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 480, image height in pixels (>=3).
REQ-003 SHALL have parameter ADDR_W, default 19, pixel address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin frame; sampled in IDLE only.
REQ-007 SHALL have port pix_req  output  1  pixel fetch request to memory.
REQ-008 SHALL have port pix_addr  output  ADDR_W  row-major address of requested pixel.
REQ-009 SHALL have port pix_valid  input  1  requested pixel present on memory data bus this cycle.
REQ-010 SHALL have port shift_enable  output  1  shift strobe to the 9-pixel window register.
REQ-011 SHALL have port clear  output  1  window register clear strobe.
REQ-012 SHALL have port window_valid  output  1  all 9 window pixels loaded.
REQ-013 SHALL have port win_ack  input  1  edge calculator consumed the window.
REQ-014 SHALL have port win_x / win_y  output  16 each  top-left coordinate of current window.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, FETCH, WIN, DONE.
REQ-018 IDLE->CLEAR on start=1; start is ignored in all other states.
REQ-019 CLEAR SHALL last exactly one cycle with clear=1, then go to FETCH with k=0, win_x=0, win_y=0.
REQ-020 In FETCH, pix_req SHALL be 1 and pix_addr SHALL equal (win_y+k/3)*IMG_W + win_x + k%3, with k the 0..8 fetch counter.
REQ-021 shift_enable SHALL equal pix_valid AND state==FETCH, combinationally, so exactly one shift occurs per accepted pixel.
REQ-022 On pix_valid, k SHALL increment; pix_valid at k=8 SHALL move to WIN and reset k to 0.
REQ-023 With pix_valid held low, FETCH SHALL hold k and pix_addr indefinitely.
REQ-024 Resulting mapping: out8 = top-left (row0,col0), out0 = bottom-right (row2,col2).
REQ-025 In WIN, window_valid SHALL be 1, shift_enable 0 and pix_req 0 until win_ack=1.
REQ-026 On win_ack in WIN: if win_x<IMG_W-3, increment win_x; else set win_x=0 and increment win_y; then go to FETCH.
REQ-027 win_ack at win_x=IMG_W-3 and win_y=IMG_H-3 SHALL go to DONE instead.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-029 win_ack outside WIN and pix_valid outside FETCH SHALL be ignored.
REQ-030 The window register SHALL not be cleared between windows; 9 fresh shifts overwrite it.
REQ-031 All address arithmetic SHALL be unsigned and truncated to ADDR_W.

Reset
REQ-032 n_rst=0 SHALL immediately force IDLE, k=0, win_x=0, win_y=0.
REQ-033 During reset all outputs SHALL be 0 (pix_addr=0, win_x=win_y=0).
REQ-034 Reset mid-frame SHALL abandon the frame with no done pulse; a new start is required.

Structure
REQ-035 State enum and the window size constant (3) SHALL live in shared package edge_pkg.
REQ-036 No sub-module; the controller SHALL not instantiate the window register (the parent wires shift_enable/clear to it).

Verification (IMG_W=5, IMG_H=4 unless stated)
REQ-037 start with pix_valid=1 continuously -> clear pulse for 1 cycle, then pix_addr 0,1,2,5,6,7,10,11,12 on 9 consecutive cycles, window_valid next cycle.
REQ-038 pix_valid low for 3 cycles at k=4 -> pix_addr held at 6, shift_enable=0, exactly 9 shifts total.
REQ-039 Full frame with immediate win_ack -> 6 windows at (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), then done for 1 cycle, busy falls.
REQ-040 win_ack delayed 5 cycles -> window_valid held 5 cycles, no pix_req while waiting.
REQ-041 n_rst asserted at window (1,1), k=3 -> all outputs 0 asynchronously, no done; a later start restarts at (0,0).
REQ-042 start pulsed while busy -> ignored, window sequence unchanged.
